// File: rtl/gpr_file_sb.sv
// -----------------------------------------------------------------------------
// gpr_file_sb
//   General-purpose register file for the RISC16 core family. It has two
//   combinational read ports and one synchronous write port. Each register
//   has a scoreboard "pending" bit that issue logic uses for RAW hazard
//   detection. A sequenced clear engine zeroes the array one entry per cycle
//   after reset or on request, so the storage array itself carries no reset.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  address width; DEPTH = 2**ADDR_W entries
//   ZERO_R0 when 1, register 0 reads as zero and ignores writes and sb sets
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   clr_req_i / clr_busy_o    clear request / clear engine running
//   wr_en_i, wr_addr_i, wr_data_i     write port
//   rd_addr_{1,2}_i, rd_data_{1,2}_o  combinational read ports
//   sb_set_en_i, sb_set_addr_i        mark a register pending
//   sb_busy_{1,2}_o                   pending status of the read addresses
//
// Build option
//   GPR_BYPASS_EN  when defined, a write in flight is forwarded to a read
//                  port that addresses the same register in the same cycle.
// -----------------------------------------------------------------------------
module gpr_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_1_i,
  input  logic [ADDR_W-1:0] rd_addr_2_i,
  output logic [DATA_W-1:0] rd_data_1_o,
  output logic [DATA_W-1:0] rd_data_2_o,
  input  logic              sb_set_en_i,
  input  logic [ADDR_W-1:0] sb_set_addr_i,
  output logic              sb_busy_1_o,
  output logic              sb_busy_2_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic [DEPTH-1:0]    sb_q;
  logic [DEPTH-1:0]    sb_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                idle;
  logic                wr_ok;    // write accepted (R0 writes filtered)
  logic                set_ok;   // scoreboard set accepted (R0 filtered)
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign idle       = (state_q == ST_IDLE);
  assign clr_busy_o = (state_q == ST_CLEAR);

  // A clear request wins over a concurrent write or scoreboard set.
  assign wr_ok  = idle && !clr_req_i && wr_en_i &&
                  !((ZERO_R0 != 0) && (wr_addr_i == '0));
  assign set_ok = idle && !clr_req_i && sb_set_en_i &&
                  !((ZERO_R0 != 0) && (sb_set_addr_i == '0));

  // Set is applied after clear so a new producer issuing while the old one
  // retires leaves the register pending.
  // NOTE: blocking assignments in combinational logic, with every output given
  // a default first so no latch is inferred.
  always_comb begin
    sb_d = sb_q;
    if (wr_ok)  sb_d[wr_addr_i]     = 1'b0;
    if (set_ok) sb_d[sb_set_addr_i] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      sb_q      <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);  // wraps to 0 after DEPTH-1
          if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_q <= ST_IDLE;
        end
        default: begin
          if (clr_req_i) begin
            state_q <= ST_CLEAR;
            sb_q    <= '0;
          end else begin
            sb_q    <= sb_d;
          end
        end
      endcase
    end
  end

  // The clear engine and the write port share the single array write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    if (!idle) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we    = 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the clear engine zeroes it, and the
  // read ports are forced to zero until that has finished.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Read ports, evaluated identically for both addresses.
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[0] = rd_addr_1_i;
  assign rd_addr[1] = rd_addr_2_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (idle && !((ZERO_R0 != 0) && (rd_addr[p] == '0))) begin
        rd_data[p] = mem_q[rd_addr[p]];
        rd_busy[p] = sb_q[rd_addr[p]];
`ifdef GPR_BYPASS_EN
        // Write-through: forward the write in flight; the register is only
        // still pending if a new producer targets it in the same cycle.
        if (wr_ok && (wr_addr_i == rd_addr[p])) begin
          rd_data[p] = wr_data_i;
          rd_busy[p] = set_ok && (sb_set_addr_i == rd_addr[p]);
        end
`endif
      end
    end
  end

  assign rd_data_1_o = rd_data[0];
  assign rd_data_2_o = rd_data[1];
  assign sb_busy_1_o = rd_busy[0];
  assign sb_busy_2_o = rd_busy[1];

endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              clr_req, wr_en, sb_set_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr_1, rd_addr_2, sb_set_addr;
  logic [DATA_W-1:0] wr_data;

  logic              clr_busy, sb_busy_1, sb_busy_2;
  logic [DATA_W-1:0] rd_data_1, rd_data_2;
  logic              z_clr_busy, z_sb_busy_1, z_sb_busy_2;
  logic [DATA_W-1:0] z_rd_data_1, z_rd_data_2;

  always #5 clk = ~clk;

  gpr_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .clr_req_i(clr_req), .clr_busy_o(clr_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_1_i(rd_addr_1), .rd_addr_2_i(rd_addr_2),
    .rd_data_1_o(rd_data_1), .rd_data_2_o(rd_data_2),
    .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr),
    .sb_busy_1_o(sb_busy_1), .sb_busy_2_o(sb_busy_2)
  );

  gpr_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .clr_req_i(clr_req), .clr_busy_o(z_clr_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_1_i(rd_addr_1), .rd_addr_2_i(rd_addr_2),
    .rd_data_1_o(z_rd_data_1), .rd_data_2_o(z_rd_data_2),
    .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr),
    .sb_busy_1_o(z_sb_busy_1), .sb_busy_2_o(z_sb_busy_2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              set_en;
    logic [ADDR_W-1:0] set_addr;
    logic [ADDR_W-1:0] ra1, ra2;
    logic [DATA_W-1:0] exp_d1, exp_d2;
    logic              exp_b1, exp_b2;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] d1, d2;
    logic              b1, b2;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic we, input int wa, input int wd, input logic se,
                              input int sa, input int r1, input int r2,
                              input int d1, input int d2, input logic b1, input logic b2);
    vec_t v;
    v.wr_en = we; v.wr_addr = ADDR_W'(wa); v.wr_data = DATA_W'(wd);
    v.set_en = se; v.set_addr = ADDR_W'(sa);
    v.ra1 = ADDR_W'(r1); v.ra2 = ADDR_W'(r2);
    v.exp_d1 = DATA_W'(d1); v.exp_d2 = DATA_W'(d2); v.exp_b1 = b1; v.exp_b2 = b2;
    return v;
  endfunction

  task automatic idle_inputs();
    clr_req = 0; wr_en = 0; sb_set_en = 0;
    wr_addr = '0; wr_data = '0; sb_set_addr = '0;
  endtask

  // Checks the clear engine over the next DEPTH edges: busy after edges
  // 1..DEPTH-1, idle after edge DEPTH; reads stay forced to zero meanwhile.
  task automatic clear_window(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk); #1;
      if (i < DEPTH) begin
        check({tag, "_busy"}, clr_busy, 1);
        check({tag, "_rd0"}, rd_data_1, 0);
      end else begin
        check({tag, "_done"}, clr_busy, 0);
        check({tag, "_z_done"}, z_clr_busy, 0);
      end
    end
  endtask

  task automatic all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_1 = ADDR_W'(a); rd_addr_2 = ADDR_W'(DEPTH - 1 - a);
      #1;
      check({tag, "_d1"}, rd_data_1, 0);
      check({tag, "_d2"}, rd_data_2, 0);
      check({tag, "_b"}, {sb_busy_1, sb_busy_2}, 0);
    end
  endtask

  initial begin
    idle_inputs();
    rd_addr_1 = 5; rd_addr_2 = 5;
    rst = 1;
    #1;
    check("rst_clr_busy", clr_busy, 1);
    check("rst_rd", {rd_data_1, rd_data_2}, 0);
    check("rst_sb", {sb_busy_1, sb_busy_2, z_sb_busy_1, z_sb_busy_2}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_busy", clr_busy, 1);
    // Release and try to write / set during the clear: must be ignored.
    rst = 0;
    wr_en = 1; wr_addr = 5; wr_data = 16'hDEAD; sb_set_en = 1; sb_set_addr = 5;
    clear_window("post_rst");
    idle_inputs();
    #1;
    check("clr_ignored_wr", rd_data_1, 0);
    check("clr_ignored_set", sb_busy_1, 0);

    // Table: inputs are driven, reads sampled before the edge, then the edge.
    vecs.push_back(mk(1, 5, 'hBEEF, 0, 0, 5, 5, BYP ? 'hBEEF : 0, BYP ? 'hBEEF : 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 5, 5, 'hBEEF, 'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0,      1, 3, 3, 5, 0, 'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 3, 3, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3, 'h0033, 0, 0, 3, 0, BYP ? 'h33 : 0, 0, BYP ? 1'b0 : 1'b1, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 3, 3, 'h33, 'h33, 0, 0));
    vecs.push_back(mk(1, 3, 'h4444, 1, 3, 3, 2, BYP ? 'h4444 : 'h33, 0, BYP ? 1'b1 : 1'b0, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 3, 3, 'h4444, 'h4444, 1, 1));
    vecs.push_back(mk(1, 1, 'hA5A5, 0, 0, 1, 3, BYP ? 'hA5A5 : 0, 'h4444, 0, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0, 1, 1, 'hA5A5, 'hA5A5, 0, 0));
    vecs.push_back(mk(1, 2, 'h1234, 0, 0, 2, 7, BYP ? 'h1234 : 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 'h1234, 0, 0, 2, 7, 'h1234, BYP ? 'h1234 : 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,      1, 6, 2, 7, 'h1234, 'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 6, 7, 0, 'h1234, 1, 0));

    foreach (vecs[i]) begin
      exp_t e;
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      sb_set_en = vecs[i].set_en; sb_set_addr = vecs[i].set_addr;
      rd_addr_1 = vecs[i].ra1; rd_addr_2 = vecs[i].ra2;
      e.d1 = vecs[i].exp_d1; e.d2 = vecs[i].exp_d2; e.b1 = vecs[i].exp_b1; e.b2 = vecs[i].exp_b2;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d_d1", i), rd_data_1, e.d1);
      check($sformatf("vec%0d_d2", i), rd_data_2, e.d2);
      check($sformatf("vec%0d_b1", i), sb_busy_1, e.b1);
      check($sformatf("vec%0d_b2", i), sb_busy_2, e.b2);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Clear request with a concurrent write and set to r4: both dropped.
    clr_req = 1; wr_en = 1; wr_addr = 4; wr_data = 16'h9999; sb_set_en = 1; sb_set_addr = 4;
    @(posedge clk); #1;
    idle_inputs();
    check("clr_req_rise", clr_busy, 1);
    clear_window("clr_req");
    all_zero("after_clr");

    // Register 0: normal instance stores it, ZERO_R0 instance discards it.
    wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; sb_set_en = 1; sb_set_addr = 0;
    rd_addr_1 = 0; rd_addr_2 = 0;
    #1;
    check("z_r0_same_cycle", {z_rd_data_1, z_sb_busy_1}, 0);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("r0_data", rd_data_1, 16'hFFFF);
    check("r0_busy", sb_busy_2, 1);
    check("z_r0_data", {z_rd_data_1, z_rd_data_2}, 0);
    check("z_r0_busy", {z_sb_busy_1, z_sb_busy_2}, 0);

    // Reset in the middle of a clear restarts it from entry 0.
    clr_req = 1;
    @(posedge clk); #1;
    clr_req = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    check("midclr_rst_busy", clr_busy, 1);
    @(posedge clk); #1;
    rst = 0;
    clear_window("midclr");
    all_zero("after_midclr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
